// File: rtl/multiplexor_n_registrado.sv
// Registered N-to-1 data selector with direct and channel-scan modes.
// Out-of-range direct selects hold the output and raise a sticky sel_error.
module multiplexor_n_registrado #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N_IN  = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] dato_in,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  modo,
  input  logic                  en,
  input  logic                  clr_error,
  output logic [WIDTH-1:0]      salida,
  output logic                  salida_valid,
  output logic [SEL_W-1:0]      canal_actual,
  output logic                  sel_error
);

  localparam logic [SEL_W-1:0] LastCh = SEL_W'(N_IN - 1);
  localparam logic [SEL_W:0]   NumCh  = (SEL_W + 1)'(N_IN);

  logic [WIDTH-1:0] salida_q, salida_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] canal_q, canal_d;
  logic             sel_error_q, sel_error_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             modo_prev_q;

  logic             entering;
  logic             sel_ok;
  logic             set_error;
  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] dato_sel;

  always_comb begin
    entering  = modo & ~modo_prev_q;
    sel_ok    = ({1'b0, sel} < NumCh);
    idx       = modo ? (entering ? '0 : ptr_q) : sel;
    dato_sel  = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (idx == SEL_W'(k)) dato_sel = dato_in[k*WIDTH +: WIDTH];
    end

    salida_d  = salida_q;
    canal_d   = canal_q;
    valid_d   = 1'b0;
    ptr_d     = ptr_q;
    set_error = 1'b0;

    if (modo) begin
      // A fresh entry into scan always restarts at channel 0, even without a capture.
      if (entering) ptr_d = '0;
      if (en) begin
        salida_d = dato_sel;
        canal_d  = idx;
        valid_d  = 1'b1;
        ptr_d    = (idx == LastCh) ? '0 : idx + 1'b1;
      end
    end else if (en) begin
      if (sel_ok) begin
        salida_d = dato_sel;
        canal_d  = idx;
        valid_d  = 1'b1;
      end else begin
        set_error = 1'b1;
      end
    end

    // Set has priority over clear.
    sel_error_d = set_error | (sel_error_q & ~clr_error);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      salida_q    <= '0;
      valid_q     <= 1'b0;
      canal_q     <= '0;
      sel_error_q <= 1'b0;
      ptr_q       <= '0;
      modo_prev_q <= 1'b0;
    end else begin
      salida_q    <= salida_d;
      valid_q     <= valid_d;
      canal_q     <= canal_d;
      sel_error_q <= sel_error_d;
      ptr_q       <= ptr_d;
      modo_prev_q <= modo;
    end
  end

  assign salida       = salida_q;
  assign salida_valid = valid_q;
  assign canal_actual = canal_q;
  assign sel_error    = sel_error_q;

endmodule

// File: tb/tb_multiplexor_n_registrado.sv
// Directed bench: default 3x16 instance plus a 5x8 instance for the parameter sweep.
module tb_multiplexor_n_registrado;

  logic clk;
  int   n_checks;
  int   n_pass;

  // Default instance: WIDTH=16, N_IN=3, SEL_W=2
  logic        reset, modo, en, clr_error;
  logic [47:0] dato_in;
  logic [1:0]  sel;
  logic [15:0] salida;
  logic        salida_valid, sel_error;
  logic [1:0]  canal_actual;

  // Sweep instance: WIDTH=8, N_IN=5, SEL_W=3
  logic        reset5, modo5, en5, clr5;
  logic [39:0] dato5;
  logic [2:0]  sel5;
  logic [7:0]  salida5;
  logic        valid5, err5;
  logic [2:0]  canal5;

  multiplexor_n_registrado dut (
    .clk          (clk),
    .reset        (reset),
    .dato_in      (dato_in),
    .sel          (sel),
    .modo         (modo),
    .en           (en),
    .clr_error    (clr_error),
    .salida       (salida),
    .salida_valid (salida_valid),
    .canal_actual (canal_actual),
    .sel_error    (sel_error)
  );

  multiplexor_n_registrado #(
    .WIDTH (8),
    .N_IN  (5),
    .SEL_W (3)
  ) dut5 (
    .clk          (clk),
    .reset        (reset5),
    .dato_in      (dato5),
    .sel          (sel5),
    .modo         (modo5),
    .en           (en5),
    .clr_error    (clr5),
    .salida       (salida5),
    .salida_valid (valid5),
    .canal_actual (canal5),
    .sel_error    (err5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] scan_exp [5];
  logic [7:0]  scan5_exp [6];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    scan_exp  = '{16'h1111, 16'h2222, 16'h3333, 16'h1111, 16'h2222};
    scan5_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h11};

    dato_in = {16'h3333, 16'h2222, 16'h1111};
    reset = 1'b1; modo = 1'b0; en = 1'b0; clr_error = 1'b0; sel = 2'd0;
    dato5 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    reset5 = 1'b1; modo5 = 1'b0; en5 = 1'b0; clr5 = 1'b0; sel5 = 3'd0;

    // 1. Reset, then direct select
    cyc(); cyc();
    check("rst_salida", 32'(salida), 32'h0);
    check("rst_valid", 32'(salida_valid), 32'h0);
    check("rst_canal", 32'(canal_actual), 32'h0);
    check("rst_err", 32'(sel_error), 32'h0);
    reset = 1'b0; en = 1'b1; sel = 2'd1;
    cyc();
    check("dir1_salida", 32'(salida), 32'h2222);
    check("dir1_canal", 32'(canal_actual), 32'h1);
    check("dir1_valid", 32'(salida_valid), 32'h1);
    en = 1'b0;
    cyc();
    check("hold_salida", 32'(salida), 32'h2222);
    check("hold_valid", 32'(salida_valid), 32'h0);
    dato_in = 48'hDEAD_BEEF_CAFE;
    cyc();
    check("hold_dato_chg", 32'(salida), 32'h2222);
    dato_in = {16'h3333, 16'h2222, 16'h1111};

    // 2. Out-of-range select
    en = 1'b1; sel = 2'd3;
    cyc();
    check("oor_salida", 32'(salida), 32'h2222);
    check("oor_canal", 32'(canal_actual), 32'h1);
    check("oor_valid", 32'(salida_valid), 32'h0);
    check("oor_err", 32'(sel_error), 32'h1);
    sel = 2'd0;
    cyc();
    check("dir0_salida", 32'(salida), 32'h1111);
    check("dir0_err_sticky", 32'(sel_error), 32'h1);

    // 3. Clear, and set-over-clear priority
    en = 1'b0; clr_error = 1'b1;
    cyc();
    check("clr_err", 32'(sel_error), 32'h0);
    en = 1'b1; sel = 2'd3;
    cyc();
    check("set_wins", 32'(sel_error), 32'h1);
    clr_error = 1'b0; en = 1'b0;
    cyc();

    // 4. Scan wrap, then an idle step with no pointer advance
    modo = 1'b1; en = 1'b1; sel = 2'd3;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("scan%0d_salida", i), 32'(salida), 32'(scan_exp[i]));
      check($sformatf("scan%0d_canal", i), 32'(canal_actual), 32'(i % 3));
      check($sformatf("scan%0d_valid", i), 32'(salida_valid), 32'h1);
    end
    en = 1'b0;
    cyc();
    check("scan_idle_valid", 32'(salida_valid), 32'h0);
    check("scan_idle_salida", 32'(salida), 32'h2222);
    en = 1'b1;
    cyc();
    check("scan_resume", 32'(salida), 32'h3333);
    check("scan_no_err", 32'(sel_error), 32'h1);

    // 5. Re-entry restarts at channel 0; reset mid-scan clears pointer
    cyc();  // ch0
    cyc();  // ch1, ptr now 2
    check("pre_exit", 32'(salida), 32'h2222);
    modo = 1'b0; en = 1'b0;
    cyc(); cyc();
    modo = 1'b1; en = 1'b1;
    cyc();
    check("reentry_salida", 32'(salida), 32'h1111);
    check("reentry_canal", 32'(canal_actual), 32'h0);
    reset = 1'b1;
    cyc();
    check("midrst_salida", 32'(salida), 32'h0);
    check("midrst_valid", 32'(salida_valid), 32'h0);
    check("midrst_err", 32'(sel_error), 32'h0);
    reset = 1'b0;
    cyc();
    check("postrst_scan0", 32'(salida), 32'h1111);
    cyc();
    check("postrst_scan1", 32'(salida), 32'h2222);

    // 6. Parameter sweep on the 5x8 instance
    cyc();
    reset5 = 1'b0; en5 = 1'b1; sel5 = 3'd4;
    cyc();
    check("p5_top_salida", 32'(salida5), 32'h55);
    check("p5_top_canal", 32'(canal5), 32'h4);
    for (int s = 5; s < 8; s++) begin
      en5 = 1'b0; clr5 = 1'b1;
      cyc();
      check($sformatf("p5_clr%0d", s), 32'(err5), 32'h0);
      clr5 = 1'b0; en5 = 1'b1; sel5 = 3'(s);
      cyc();
      check($sformatf("p5_err%0d", s), 32'(err5), 32'h1);
      check($sformatf("p5_hold%0d", s), 32'(salida5), 32'h55);
    end
    en5 = 1'b0; clr5 = 1'b1;
    cyc();
    clr5 = 1'b0; modo5 = 1'b1; en5 = 1'b1; sel5 = 3'd7;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check($sformatf("p5_scan%0d", i), 32'(salida5), 32'(scan5_exp[i]));
    end
    check("p5_scan_no_err", 32'(err5), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
